info_frame_builder: RTL and testbench

Runtime-programmable, double-buffered HDMI InfoFrame packet source, generalising the fixed audio InfoFrame to any CEA-861 InfoFrame type and length. Host logic writes payload bytes (PB1..PB[LENGTH]) into a shadow buffer and pulses `commit`. The block then computes the checksum sequentially and swaps the new frame into the active buffer only at a packet boundary signalled by the packet picker. The active buffer drives `header`/`sub` directly into the HDMI data-island packet assembler; output never changes mid-packet.

---
 rtl/info_frame_builder.sv | 143 ++++++++++++++
 tb/tb_info_frame_builder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/info_frame_builder.sv
// info_frame_builder
// Double-buffered, runtime-programmable HDMI InfoFrame source. The host fills a
// shadow payload buffer and pulses commit; the checksum is then accumulated one
// byte per cycle, and the finished frame is swapped into the active buffer only
// on a packet boundary so the packet assembler never sees a frame change
// mid-packet.
module info_frame_builder #(
  parameter logic [7:0] TYPE    = 8'h84,
  parameter logic [7:0] VERSION = 8'd1,
  parameter logic [4:0] LENGTH  = 5'd10
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  input  logic        packet_boundary,
  output logic [23:0] header,
  output logic [55:0] sub [3:0],
  output logic        frame_valid,
  output logic        busy
);

  // PB0..PB27: four subpackets of seven bytes each.
  localparam int unsigned NUM_PB = 28;

  localparam logic [7:0] HB2        = {3'b000, LENGTH};
  localparam logic [7:0] HEADER_SUM = 8'(TYPE + VERSION + HB2);

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    PENDING
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  checksum_q, checksum_d;
  logic [7:0]  shadow_q [NUM_PB];
  logic [7:0]  shadow_d [NUM_PB];
  logic [7:0]  active_q [NUM_PB];
  logic [7:0]  active_d [NUM_PB];
  logic        frame_valid_q, frame_valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  sum_next;

  // Header bytes are fixed by the parameters and never pass through a register.
  assign header = {HB2, VERSION, TYPE};

  // Next-state logic: shadow writes, checksum accumulation, and the boundary swap.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    acc_d         = acc_q;
    index_d       = index_q;
    checksum_d    = checksum_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    frame_valid_d = frame_valid_q;
    sum_next      = acc_q + shadow_q[index_q];

    // Writes are only accepted while idle, so the bytes being summed are
    // frozen for the whole commit. PB0 is the checksum and is not writable.
    if (wr_en && !busy_q && (wr_addr != 5'd0) && (wr_addr <= LENGTH)) begin
      shadow_d[wr_addr] = wr_data;
    end

    unique case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = SUM;
          acc_d   = HEADER_SUM;
          index_d = 5'd1;
        end
      end
      SUM: begin
        acc_d   = sum_next;
        index_d = index_q + 5'd1;
        if (index_q == LENGTH) begin
          state_d    = PENDING;
          checksum_d = 8'h00 - sum_next;
        end
      end
      PENDING: begin
        if (packet_boundary) begin
          active_d[0] = checksum_q;
          for (int i = 1; i < NUM_PB; i++) begin
            active_d[i] = (i <= int'(LENGTH)) ? shadow_q[i] : 8'h00;
          end
          frame_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk_pixel) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from the same edge, independent of statement order.
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= 8'h00;
      index_q       <= 5'd0;
      checksum_q    <= 8'h00;
      // NOTE: both buffers are cleared on reset because a reset must blank
      // the outgoing frame (sub = 0), so they are flops rather than RAM.
      shadow_q      <= '{default: 8'h00};
      active_q      <= '{default: 8'h00};
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      index_q       <= index_d;
      checksum_q    <= checksum_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Subpacket i carries PB[7i]..PB[7i+6], lowest byte in the low bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sub[i] = '0;
      for (int k = 0; k < 7; k++) begin
        sub[i][8*k +: 8] = active_q[7*i + k];
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_info_frame_builder.sv
// tb_info_frame_builder
// Three instances (LENGTH 10, 27, 1) driven by directed steps and random
// frames, checked against a byte-array model of the InfoFrame buffers.
`timescale 1ns/1ps
module tb_info_frame_builder;

  logic              clk;
  logic [2:0]        reset;
  logic [2:0]        wr_en;
  logic [4:0]        wr_addr [3];
  logic [7:0]        wr_data [3];
  logic [2:0]        commit;
  logic [2:0]        pb;
  logic [23:0]       header_v [3];
  logic [55:0]       sub_0 [3:0];
  logic [55:0]       sub_1 [3:0];
  logic [55:0]       sub_2 [3:0];
  logic [2:0]        fv_v;
  logic [2:0]        busy_v;

  int checks = 0;
  int errors = 0;

  int lens [3] = '{10, 27, 1};

  // Reference model state per instance.
  logic [7:0] mshadow [3][28];
  logic [7:0] mactive [3][28];
  bit         mbusy   [3];
  bit         mfv     [3];

  info_frame_builder u_dut0 (
    .clk_pixel(clk), .reset(reset[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .commit(commit[0]), .packet_boundary(pb[0]),
    .header(header_v[0]), .sub(sub_0), .frame_valid(fv_v[0]), .busy(busy_v[0])
  );

  info_frame_builder #(.LENGTH(5'd27)) u_dut1 (
    .clk_pixel(clk), .reset(reset[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .commit(commit[1]), .packet_boundary(pb[1]),
    .header(header_v[1]), .sub(sub_1), .frame_valid(fv_v[1]), .busy(busy_v[1])
  );

  info_frame_builder #(.LENGTH(5'd1)) u_dut2 (
    .clk_pixel(clk), .reset(reset[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .commit(commit[2]), .packet_boundary(pb[2]),
    .header(header_v[2]), .sub(sub_2), .frame_valid(fv_v[2]), .busy(busy_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [223:0] obs, logic [223:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset(int n);
    for (int j = 0; j < 28; j++) begin
      mshadow[n][j] = 8'h00;
      mactive[n][j] = 8'h00;
    end
    mbusy[n] = 1'b0;
    mfv[n]   = 1'b0;
  endfunction

  function automatic void model_write(int n, int a, logic [7:0] d);
    if (!mbusy[n] && a >= 1 && a <= lens[n]) mshadow[n][a] = d;
  endfunction

  function automatic void model_commit(int n);
    if (!mbusy[n]) mbusy[n] = 1'b1;
  endfunction

  // Checksum makes header bytes plus PB0..PB[LENGTH] sum to 0 mod 256.
  function automatic void model_publish(int n);
    int s;
    s = 'h84 + 1 + lens[n];
    for (int j = 1; j < 28; j++) begin
      if (j <= lens[n]) begin
        mactive[n][j] = mshadow[n][j];
        s += mshadow[n][j];
      end else begin
        mactive[n][j] = 8'h00;
      end
    end
    mactive[n][0] = 8'((256 - (s % 256)) % 256);
    mfv[n]   = 1'b1;
    mbusy[n] = 1'b0;
  endfunction

  function automatic logic [223:0] exp_frame(int n);
    logic [223:0] f;
    f = '0;
    for (int j = 0; j < 28; j++) f[8*j +: 8] = mactive[n][j];
    return f;
  endfunction

  function automatic logic [223:0] obs_frame(int n);
    case (n)
      0:       return {sub_0[3], sub_0[2], sub_0[1], sub_0[0]};
      1:       return {sub_1[3], sub_1[2], sub_1[1], sub_1[0]};
      default: return {sub_2[3], sub_2[2], sub_2[1], sub_2[0]};
    endcase
  endfunction

  // Sum of header bytes and observed PB0..PB[LENGTH], mod 256.
  function automatic logic [7:0] obs_sum(int n);
    logic [223:0] f;
    int s;
    f = obs_frame(n);
    s = 'h84 + 1 + lens[n];
    for (int j = 0; j <= lens[n]; j++) s += int'(f[8*j +: 8]);
    return 8'(s % 256);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wr(int n, int a, logic [7:0] d);
    wr_en[n]   = 1'b1;
    wr_addr[n] = 5'(a);
    wr_data[n] = d;
    model_write(n, a, d);
    tick();
    wr_en[n] = 1'b0;
  endtask

  // Random writes, commit (optionally with a same-cycle write), random junk
  // during the commit, and randomly placed boundaries; busy is checked every
  // cycle against the cycle the model says the frame publishes on.
  task automatic run_frame(int n);
    int  nw;
    int  a;
    bit  pbv;
    bit  done;
    int  len;
    logic [7:0] d;
    len = lens[n];
    nw  = $urandom_range(0, len + 3);
    for (int i = 0; i < nw; i++) wr(n, $urandom_range(0, 31), 8'($urandom));
    a = $urandom_range(0, 31);
    d = 8'($urandom);
    wr_en[n]   = 1'($urandom_range(0, 1));
    wr_addr[n] = 5'(a);
    wr_data[n] = d;
    if (wr_en[n]) model_write(n, a, d);
    commit[n] = 1'b1;
    model_commit(n);
    tick();
    commit[n] = 1'b0;
    wr_en[n]  = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= len + 40 && !done; c++) begin
      check("busy_in_commit", 224'(busy_v[n]), 224'(1));
      pbv = (c >= len + 30) ? 1'b1 : ($urandom_range(0, 2) != 0);
      a = $urandom_range(0, 31);
      d = 8'($urandom);
      wr_en[n]   = 1'($urandom_range(0, 1));
      wr_addr[n] = 5'(a);
      wr_data[n] = d;
      commit[n]  = 1'($urandom_range(0, 1));
      if (wr_en[n]) model_write(n, a, d);
      if (commit[n]) model_commit(n);
      pb[n] = pbv;
      tick();
      if (pbv && c >= len + 1) begin
        model_publish(n);
        done = 1'b1;
      end
    end
    pb[n] = 1'b0; wr_en[n] = 1'b0; commit[n] = 1'b0;
    check("busy_after_publish", 224'(busy_v[n]), 224'(0));
    check("frame_valid", 224'(fv_v[n]), 224'(mfv[n]));
    check("frame_contents", obs_frame(n), exp_frame(n));
    check("checksum_invariant", 224'(obs_sum(n)), 224'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [223:0] held;
    reset = 3'b111; wr_en = '0; commit = '0; pb = '0;
    for (int n = 0; n < 3; n++) begin
      wr_addr[n] = '0;
      wr_data[n] = '0;
      model_reset(n);
    end
    tick(); tick();
    reset = 3'b000;

    // Reset state.
    check("reset_header0", 224'(header_v[0]), 224'(24'h0A0184));
    check("reset_header27", 224'(header_v[1]), 224'(24'h1B0184));
    check("reset_header1", 224'(header_v[2]), 224'(24'h010184));
    check("reset_sub", obs_frame(0), '0);
    check("reset_fv", 224'(fv_v[0]), 224'(0));
    check("reset_busy", 224'(busy_v[0]), 224'(0));

    // Audio 2-channel frame: PB1 = 01, boundary at t+15.
    wr(0, 1, 8'h01);
    commit[0] = 1'b1; model_commit(0); tick(); commit[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check("audio_busy", 224'(busy_v[0]), 224'(1));
      pb[0] = (k == 15);
      tick();
    end
    pb[0] = 1'b0;
    model_publish(0);
    check("audio_busy_done", 224'(busy_v[0]), 224'(0));
    check("audio_sub0", 224'(sub_0[0]), 224'(56'h00000000000170));
    check("audio_fv", 224'(fv_v[0]), 224'(1));
    check("audio_frame", obs_frame(0), exp_frame(0));

    // Update held off until boundary.
    held = obs_frame(0);
    wr(0, 1, 8'h07);
    wr(0, 4, 8'h13);
    commit[0] = 1'b1; model_commit(0); tick(); commit[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check("hold_sub", obs_frame(0), held);
      tick();
    end
    check("hold_busy", 224'(busy_v[0]), 224'(1));
    pb[0] = 1'b1; tick(); pb[0] = 1'b0;
    model_publish(0);
    check("hold_pb0", 224'(sub_0[0][7:0]), 224'(8'h57));
    check("hold_pb1", 224'(sub_0[0][15:8]), 224'(8'h07));
    check("hold_pb4", 224'(sub_0[0][39:32]), 224'(8'h13));
    check("hold_frame", obs_frame(0), exp_frame(0));

    // Ignored inputs: out-of-range writes in IDLE, writes/commits while busy.
    wr(0, 0, 8'hAA);
    wr(0, 11, 8'hBB);
    wr(0, 2, 8'h22);
    commit[0] = 1'b1; model_commit(0); tick();
    for (int k = 0; k < 14; k++) begin
      wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 8'hFF;
      model_write(0, 2, 8'hFF);
      commit[0] = 1'b1; model_commit(0);
      tick();
    end
    wr_en[0] = 1'b0; commit[0] = 1'b0;
    pb[0] = 1'b1; tick();
    model_publish(0);
    check("ignored_frame", obs_frame(0), exp_frame(0));
    check("ignored_pb2", 224'(sub_0[0][23:16]), 224'(8'h22));
    check("ignored_pb11", 224'(sub_0[1][39:32]), 224'(8'h00));
    for (int k = 0; k < 20; k++) begin
      check("no_second_pass", 224'(busy_v[0]), 224'(0));
      tick();
    end
    pb[0] = 1'b0;

    // Reset during SUM.
    wr(0, 3, 8'h5A);
    commit[0] = 1'b1; model_commit(0); tick(); commit[0] = 1'b0;
    tick(); tick();
    check("pre_reset_busy", 224'(busy_v[0]), 224'(1));
    reset[0] = 1'b1; tick(); reset[0] = 1'b0;
    model_reset(0);
    check("midsum_busy", 224'(busy_v[0]), 224'(0));
    check("midsum_fv", 224'(fv_v[0]), 224'(0));
    check("midsum_sub", obs_frame(0), '0);
    for (int k = 0; k < 3; k++) run_frame(0);

    // Random frames at the extreme lengths.
    for (int f = 0; f < 400; f++) run_frame(1);
    for (int f = 0; f < 600; f++) run_frame(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
